// File: rtl/stream_demux.sv
// stream_demux: routes one valid/ready input stream to one of NUM_OUT output
// channels chosen by in_sel. Each channel buffers its traffic in its own
// DEPTH-entry FIFO, so a stalled consumer only blocks the traffic queued for it.
module stream_demux #(
    parameter int NUM_OUT    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [DATA_WIDTH-1:0]                  in_data,
    input  logic [$clog2(NUM_OUT)-1:0]             in_sel,
    output logic [NUM_OUT-1:0]                     out_valid,
    input  logic [NUM_OUT-1:0]                     out_ready,
    output logic [NUM_OUT*DATA_WIDTH-1:0]          out_data,
    output logic [NUM_OUT*($clog2(DEPTH)+1)-1:0]   out_count
);

    localparam int SEL_W = $clog2(NUM_OUT);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q    [NUM_OUT][DEPTH];
    logic [DATA_WIDTH-1:0] mem_d    [NUM_OUT][DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q [NUM_OUT];
    logic [PTR_W-1:0]      wr_ptr_d [NUM_OUT];
    logic [PTR_W-1:0]      rd_ptr_q [NUM_OUT];
    logic [PTR_W-1:0]      rd_ptr_d [NUM_OUT];
    logic [CNT_W-1:0]      count_q  [NUM_OUT];
    logic [CNT_W-1:0]      count_d  [NUM_OUT];

    logic [NUM_OUT-1:0]    push;
    logic [NUM_OUT-1:0]    pop;

    // Accept only if the selected channel has room; depends on registered count alone.
    always_comb begin
        in_ready = !reset && (count_q[in_sel] != CNT_W'(DEPTH));
    end

    // Per-channel push/pop decode and FIFO next-state (pointers wrap naturally).
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        push     = '0;
        pop      = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            push[i] = in_valid && in_ready && (in_sel == SEL_W'(i));
            pop[i]  = (count_q[i] != '0) && out_ready[i];
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = in_data;
                wr_ptr_d[i]           = wr_ptr_q[i] + PTR_W'(1);
            end
            if (pop[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
            end
            case ({push[i], pop[i]})
                2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
                2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
                default: count_d[i] = count_q[i];
            endcase
        end
    end

    // State registers; reset discards all queued data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    mem_q[i][j] <= '0;
                end
            end
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Present each channel's head word, valid flag and occupancy on the packed buses.
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        out_count = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            out_valid[i]                          = (count_q[i] != '0);
            out_data[i*DATA_WIDTH +: DATA_WIDTH]  = mem_q[i][rd_ptr_q[i]];
            out_count[i*CNT_W +: CNT_W]           = count_q[i];
        end
    end

endmodule
